// File: rtl/fft_peak_detect.sv
// fft_peak_detect: streaming per-frame max |X[k]|^2 finder for FFT output bins.
// Define FFT_PEAK_HALF_EN to restrict the search to bins 0..N/2-1 (real-input spectra).
module fft_peak_detect #(
   parameter int DATA_W    = 16,
   parameter int NFFT_LOG2 = 10
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic [2*DATA_W-1:0]   s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   output logic                  peak_valid,
   output logic [NFFT_LOG2-1:0]  peak_bin,
   output logic [2*DATA_W-1:0]   peak_mag,
   output logic                  frame_err
);
   localparam int MW = 2*DATA_W;
   logic                     accept, at_end, elig, take;
   logic [NFFT_LOG2-1:0]     cnt, bin1, bin2, bin3, max_bin, new_bin;
   logic                     v1, v2, v3, first1, first2, first3;
   logic                     last1, last2, last3, err1, err2, err3;
   logic signed [DATA_W-1:0] re1, im1;
   logic signed [MW-1:0]     re_x, im_x;
   logic [MW-1:0]            sq_re, sq_im, mag3, max_mag, new_mag;
   assign accept = s_tvalid && s_tready;
   assign at_end = &cnt;
   assign re_x   = MW'(re1);
   assign im_x   = MW'(im1);
`ifdef FFT_PEAK_HALF_EN
   assign elig = ~bin3[NFFT_LOG2-1];
`else
   assign elig = 1'b1;
`endif
   // first bin of a frame always loads; later bins need a strict win so ties keep the lowest index
   always_comb begin
      take    = v3 && (first3 || (elig && mag3 > max_mag));
      new_mag = take ? mag3 : max_mag;
      new_bin = take ? bin3 : max_bin;
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         s_tready <= 1'b0;
         cnt      <= '0;
         v1       <= 1'b0;
         re1      <= '0;
         im1      <= '0;
         bin1     <= '0;
         first1   <= 1'b0;
         last1    <= 1'b0;
         err1     <= 1'b0;
      end else begin
         s_tready <= 1'b1;
         v1       <= accept;
         if (accept) begin
            cnt    <= (s_tlast || at_end) ? '0 : cnt + NFFT_LOG2'(1);
            re1    <= s_tdata[DATA_W-1:0];
            im1    <= s_tdata[MW-1:DATA_W];
            bin1   <= cnt;
            first1 <= cnt == '0;
            last1  <= s_tlast || at_end;
            err1   <= s_tlast ^ at_end;
         end
      end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         v2     <= 1'b0;
         sq_re  <= '0;
         sq_im  <= '0;
         bin2   <= '0;
         first2 <= 1'b0;
         last2  <= 1'b0;
         err2   <= 1'b0;
         v3     <= 1'b0;
         mag3   <= '0;
         bin3   <= '0;
         first3 <= 1'b0;
         last3  <= 1'b0;
         err3   <= 1'b0;
      end else begin
         v2     <= v1;
         sq_re  <= $unsigned(re_x * re_x);
         sq_im  <= $unsigned(im_x * im_x);
         bin2   <= bin1;
         first2 <= first1;
         last2  <= last1;
         err2   <= err1;
         v3     <= v2;
         mag3   <= sq_re + sq_im;
         bin3   <= bin2;
         first3 <= first2;
         last3  <= last2;
         err3   <= err2;
      end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         max_mag    <= '0;
         max_bin    <= '0;
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_mag   <= '0;
         frame_err  <= 1'b0;
      end else begin
         if (v3) begin
            max_mag <= new_mag;
            max_bin <= new_bin;
         end
         peak_valid <= v3 && last3;
         frame_err  <= v3 && last3 && err3;
         if (v3 && last3) begin
            peak_bin <= new_bin;
            peak_mag <= new_mag;
         end
      end
endmodule
